// File: rtl/riscv_run_monitor_pkg.sv
// Shared types and constants for the RISC-V run controller/monitor and its PC stall detector.
package riscv_run_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_HOLD = 3'd1,
    ST_RUN        = 3'd2,
    ST_HALTED     = 3'd3,
    ST_TIMEOUT    = 3'd4
  } run_state_e;

  typedef enum logic [1:0] {
    HR_NONE      = 2'd0,
    HR_HALT_INSN = 2'd1,
    HR_SELF_LOOP = 2'd2,
    HR_TIMEOUT   = 2'd3
  } halt_reason_e;

  // ebreak ends a program; "jal x0, 0" is the usual way a program parks itself in a self-loop
  localparam logic [31:0] EBREAK_INSN    = 32'h0010_0073;
  localparam logic [31:0] SELF_LOOP_INSN = 32'h0000_006F;

endpackage : riscv_run_monitor_pkg

// File: rtl/pc_stall_detector.sv
// Tracks the previous PC and how many consecutive RUN cycles it has stayed unchanged,
// flagging a PC change and the cycle on which the self-loop limit is reached.
module pc_stall_detector
  import riscv_run_monitor_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int STALL_LIMIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            en_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            changed_o,
  output logic            stalled_o
);

  localparam int SW = $clog2(STALL_LIMIT);
  // Trip when the count is one short of the limit and the PC repeats once more.
  localparam logic [SW-1:0] STALL_TRIP = SW'(STALL_LIMIT - 2);
  localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_LIMIT - 1);

  logic [XLEN-1:0] prev_pc_q, prev_pc_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            first_q, first_d;
  logic            same_pc;

  assign same_pc   = (pc_i == prev_pc_q);
  assign changed_o = en_i && !first_q && !same_pc;
  assign stalled_o = en_i && !first_q && same_pc && (stall_q == STALL_TRIP);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    prev_pc_d = prev_pc_q;
    stall_d   = stall_q;
    first_d   = first_q;
    if (clear_i) begin
      stall_d = '0;
      first_d = 1'b1;
    end else if (en_i) begin
      prev_pc_d = pc_i;
      first_d   = 1'b0;
      if (first_q || !same_pc) begin
        stall_d = '0;
      end else if (stall_q != STALL_MAX) begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_pc_q <= '0;
      stall_q   <= '0;
      first_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      prev_pc_q <= prev_pc_d;
      stall_q   <= stall_d;
      first_q   <= first_d;
    end
  end

endmodule : pc_stall_detector

// File: rtl/riscv_run_monitor.sv
// Run controller beside the RISC-V core: sequences core reset, counts cycles and retired
// instructions, detects halt / self-loop / timeout and folds Result into a signature.
module riscv_run_monitor
  import riscv_run_monitor_pkg::*;
#(
  parameter int          XLEN         = 64,
  parameter int          RESET_CYCLES = 4,
  parameter int          MAX_CYCLES   = 1500,
  parameter int          STALL_LIMIT  = 8,
  parameter logic [31:0] HALT_INSN    = EBREAK_INSN,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [31:0]      instr_in,
  input  logic [XLEN-1:0]  result_in,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic [1:0]       halt_reason,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [XLEN-1:0]  signature
);

  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

  run_state_e       state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [XLEN-1:0]  sig_q, sig_d;
  halt_reason_e     reason_q, reason_d;
  logic             done_q, done_d;

  logic             in_run;
  logic             start_run;
  logic             pc_changed;
  logic             hit_halt;
  logic             hit_loop;
  logic             hit_timeout;
  logic [CNT_W-1:0] cycle_inc;
  logic [CNT_W-1:0] instr_inc;

  assign in_run    = (state_q == ST_RUN);
  assign start_run = start && (state_q inside {ST_IDLE, ST_HALTED, ST_TIMEOUT});

  pc_stall_detector #(
    .XLEN        (XLEN),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (start_run),
    .en_i      (in_run),
    .pc_i      (pc_in),
    .changed_o (pc_changed),
    .stalled_o (hit_loop)
  );

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign cycle_inc   = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
  assign instr_inc   = (instr_q == '1) ? instr_q : instr_q + 1'b1;
  assign hit_halt    = in_run && (instr_in == HALT_INSN);
  assign hit_timeout = in_run && (cycle_inc >= CNT_W'(MAX_CYCLES));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
        if (start) state_d = ST_RESET_HOLD;
      end
      ST_RESET_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (hit_halt || hit_loop) state_d = ST_HALTED;
        else if (hit_timeout)     state_d = ST_TIMEOUT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: the core is only released while running.
  always_comb begin
    running    = in_run;
    core_reset = !in_run;
  end

  // Counters, signature and end-of-run status
  always_comb begin
    hold_d   = hold_q;
    cycle_d  = cycle_q;
    instr_d  = instr_q;
    sig_d    = sig_q;
    reason_d = reason_q;
    done_d   = 1'b0;

    if (start_run) begin
      hold_d   = '0;
      cycle_d  = '0;
      instr_d  = '0;
      sig_d    = '0;
      reason_d = HR_NONE;
    end else if (state_q == ST_RESET_HOLD) begin
      hold_d = hold_q + 1'b1;
    end else if (in_run) begin
      cycle_d = cycle_inc;
      if (pc_changed) instr_d = instr_inc;
      sig_d = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ result_in;
      if (hit_halt) begin
        reason_d = HR_HALT_INSN;
        done_d   = 1'b1;
      end else if (hit_loop) begin
        reason_d = HR_SELF_LOOP;
        done_d   = 1'b1;
      end else if (hit_timeout) begin
        reason_d = HR_TIMEOUT;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q   <= '0;
      cycle_q  <= '0;
      instr_q  <= '0;
      sig_q    <= '0;
      reason_q <= HR_NONE;
      done_q   <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      cycle_q  <= cycle_d;
      instr_q  <= instr_d;
      sig_q    <= sig_d;
      reason_q <= reason_d;
      done_q   <= done_d;
    end
  end

  assign done        = done_q;
  assign halt_reason = reason_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign signature   = sig_q;

endmodule : riscv_run_monitor

// File: tb/tb_riscv_run_monitor.sv
// Scoreboard bench for riscv_run_monitor: a reference model predicts each run's end state,
// which is queued at stimulus time and compared when done pulses.
module tb_riscv_run_monitor;

  localparam int XLEN         = 64;
  localparam int RESET_CYCLES = 4;
  localparam int MAX_CYCLES   = 20;
  localparam int STALL_LIMIT  = 8;
  localparam int CNT_W        = 32;
  localparam int NSTIM        = 32;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [XLEN-1:0]  pc_in;
  logic [31:0]      instr_in;
  logic [XLEN-1:0]  result_in;
  logic             core_reset;
  logic             running;
  logic             done;
  logic [1:0]       halt_reason;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;
  logic [XLEN-1:0]  signature;

  typedef struct {
    logic [1:0]  reason;
    logic [31:0] cycles;
    logic [31:0] instrs;
    logic [63:0] sig;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] stim_pc  [NSTIM];
  logic [31:0] stim_in  [NSTIM];
  logic [63:0] stim_res [NSTIM];

  riscv_run_monitor #(
    .XLEN         (XLEN),
    .RESET_CYCLES (RESET_CYCLES),
    .MAX_CYCLES   (MAX_CYCLES),
    .STALL_LIMIT  (STALL_LIMIT),
    .HALT_INSN    (EBREAK),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc_in       (pc_in),
    .instr_in    (instr_in),
    .result_in   (result_in),
    .core_reset  (core_reset),
    .running     (running),
    .done        (done),
    .halt_reason (halt_reason),
    .cycle_count (cycle_count),
    .instr_count (instr_count),
    .signature   (signature)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model of one run, written directly from the run rules.
  function automatic exp_t model_run();
    exp_t        e;
    logic [63:0] prev;
    int          stall;
    bit          same;
    e.reason = 2'd0;
    e.cycles = '0;
    e.instrs = '0;
    e.sig    = '0;
    prev     = '0;
    stall    = 0;
    for (int k = 0; k < NSTIM; k++) begin
      same     = (k > 0) && (stim_pc[k] == prev);
      e.cycles = e.cycles + 1;
      if (k > 0 && !same) begin
        e.instrs = e.instrs + 1;
        stall    = 0;
      end else if (same) begin
        stall++;
      end else begin
        stall = 0;
      end
      prev  = stim_pc[k];
      e.sig = {e.sig[62:0], e.sig[63]} ^ stim_res[k];
      if (stim_in[k] == EBREAK) begin
        e.reason = 2'd1;
        return e;
      end
      if (same && stall == STALL_LIMIT - 1) begin
        e.reason = 2'd2;
        return e;
      end
      if (e.cycles == MAX_CYCLES) begin
        e.reason = 2'd3;
        return e;
      end
    end
    return e;
  endfunction

  task automatic fill_default();
    for (int k = 0; k < NSTIM; k++) begin
      stim_pc[k]  = 64'h1000 + 64'(4 * k);
      stim_in[k]  = NOP;
      stim_res[k] = {$urandom, $urandom};
    end
  endtask

  task automatic fill_random();
    int halt_at;
    stim_pc[0] = {$urandom, $urandom} & ~64'h3;
    for (int k = 0; k < NSTIM; k++) begin
      if (k > 0) stim_pc[k] = ($urandom_range(0, 2) == 0) ? stim_pc[k-1] + 64'd4 : stim_pc[k-1];
      stim_in[k]  = $urandom;
      if (stim_in[k] == EBREAK) stim_in[k] = NOP;
      stim_res[k] = {$urandom, $urandom};
    end
    halt_at = $urandom_range(2, NSTIM - 1);
    stim_in[halt_at] = EBREAK;
  endtask

  // One full run: start, reset hold, drive the program until done, then check the frozen state.
  task automatic run_program(input bit start_in_hold, input int start_in_run_at);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    sb_q.push_back(model_run());

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("clr_cycle", 64'(cycle_count), 64'd0);
    check("clr_instr", 64'(instr_count), 64'd0);
    check("clr_sig", signature, 64'd0);
    check("clr_reason", 64'(halt_reason), 64'd0);
    check("hold_core_reset", 64'(core_reset), 64'd1);
    for (int i = 1; i < RESET_CYCLES; i++) begin
      if (start_in_hold && i == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_core_reset", 64'(core_reset), 64'd1);
      check("hold_running", 64'(running), 64'd0);
    end
    @(posedge clk); #1;
    check("run_core_reset", 64'(core_reset), 64'd0);
    check("run_running", 64'(running), 64'd1);

    for (int k = 0; k < NSTIM; k++) begin
      pc_in     = stim_pc[k];
      instr_in  = stim_in[k];
      result_in = stim_res[k];
      start     = (k == start_in_run_at);
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      check("running_mid", 64'(running), 64'd1);
    end

    if (!seen) begin
      check("done_seen", 64'd0, 64'd1);
      void'(sb_q.pop_front());
      return;
    end
    e = sb_q.pop_front();
    check("end_reason", 64'(halt_reason), 64'(e.reason));
    check("end_cycles", 64'(cycle_count), 64'(e.cycles));
    check("end_instrs", 64'(instr_count), 64'(e.instrs));
    check("end_sig", signature, e.sig);
    check("end_core_reset", 64'(core_reset), 64'd1);
    check("end_running", 64'(running), 64'd0);

    pc_in     = {$urandom, $urandom};
    result_in = {$urandom, $urandom};
    instr_in  = NOP;
    @(posedge clk); #1;
    check("done_once", 64'(done), 64'd0);
    check("frozen_sig", signature, e.sig);
    check("frozen_cycles", 64'(cycle_count), 64'(e.cycles));
    check("frozen_reason", 64'(halt_reason), 64'(e.reason));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    pc_in     = '0;
    instr_in  = NOP;
    result_in = '0;
    #1;
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_running", 64'(running), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_reason", 64'(halt_reason), 64'd0);
    check("rst_cycle", 64'(cycle_count), 64'd0);
    check("rst_sig", signature, 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Signature of three Result=1 cycles from zero, halting on the third.
    fill_default();
    stim_pc[0] = 64'h0; stim_pc[1] = 64'h4; stim_pc[2] = 64'h8;
    stim_res[0] = 64'd1; stim_res[1] = 64'd1; stim_res[2] = 64'd1;
    stim_in[2] = EBREAK;
    run_program(1'b0, -1);
    check("sig_seven", signature, 64'd7);

    // PC 0,4,8,C then ebreak with PC held.
    fill_default();
    stim_pc[0] = 64'h0; stim_pc[1] = 64'h4; stim_pc[2] = 64'h8;
    stim_pc[3] = 64'hC; stim_pc[4] = 64'hC;
    stim_in[4] = EBREAK;
    run_program(1'b0, -1);
    check("halt_instr_cnt", 64'(instr_count), 64'd3);
    check("halt_cycle_cnt", 64'(cycle_count), 64'd5);

    // PC parked at 0x40 for STALL_LIMIT cycles.
    fill_default();
    for (int k = 0; k < STALL_LIMIT; k++) stim_pc[k] = 64'h40;
    run_program(1'b0, -1);
    check("loop_reason", 64'(halt_reason), 64'd2);

    // Timeout with start pulses during hold and during run.
    fill_default();
    run_program(1'b1, 5);
    check("timeout_cycles", 64'(cycle_count), 64'(MAX_CYCLES));

    // Stall one short of the limit, then a real self-loop at the next PC.
    fill_default();
    for (int k = 0; k < 7; k++)  stim_pc[k] = 64'h40;
    for (int k = 7; k < 15; k++) stim_pc[k] = 64'h44;
    run_program(1'b0, -1);

    // Halt instruction wins over a self-loop on the same cycle.
    fill_default();
    for (int k = 0; k < STALL_LIMIT; k++) stim_pc[k] = 64'h80;
    stim_in[STALL_LIMIT-1] = EBREAK;
    run_program(1'b0, -1);

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (RESET_CYCLES) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      pc_in     = 64'h2000 + 64'(4 * k);
      result_in = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    check("mid_rst_core_reset", 64'(core_reset), 64'd1);
    check("mid_rst_running", 64'(running), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_reason", 64'(halt_reason), 64'd0);
    check("mid_rst_cycle", 64'(cycle_count), 64'd0);
    check("mid_rst_instr", 64'(instr_count), 64'd0);
    check("mid_rst_sig", signature, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("post_rst_done", 64'(done), 64'd0);
      check("post_rst_idle", 64'(running), 64'd0);
    end

    // Random programs judged only by the model.
    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_program(1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_riscv_run_monitor
